clk_div_sched: RTL and testbench
================================

# clk_div_sched

Programmable tick scheduler that sequences a divide-by-N counter: run/stop control, finite bursts or continuous ticking, and a handshake to reload the divide ratio between runs. Sits between the system controller (FSM or button logic) and the consumers of slow enables, such as display refresh, debouncers and LED blinkers. It replaces free-running fixed dividers wherever the rate or duration must change at run time.

## Interface
- `WIDTH`, 32: width of the divide ratio and the internal counter.
- `DEFAULT_DIV`, 50_000_000: divide ratio loaded at reset.
- `BURST_W`, 16: width of the burst length.

- `clk_in`, input, 1: system clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cfg_valid`, input, 1: new divide ratio offered.
- `cfg_div`, input, WIDTH: divide ratio; 0 is stored as 1.
- `cfg_ready`, output, 1: ratio can be accepted (high only in IDLE).
- `cmd_start`, input, 1: begin a run; sampled in IDLE only.
- `cmd_stop`, input, 1: abort a run; highest priority.
- `burst_len`, input, BURST_W: ticks to emit, sampled with `cmd_start`; 0 means continuous.
- `tick`, output, 1: one-cycle enable pulse every `div` cycles while running.
- `clk_out`, output, 1: square wave toggling on every tick (period 2·div).
- `busy`, output, 1: high in RUN.
- `done`, output, 1: one-cycle pulse when a burst completes normally.

## Operation
- State machine has two states, IDLE and RUN. Reset enters IDLE.
- Reset values:
  - Outputs: `tick`=0, `clk_out`=0, `busy`=0, `done`=0, `cfg_ready`=1.
  - Internal: `div`=DEFAULT_DIV, count=0, remaining=0.
- **Config:**
  - In IDLE, `cfg_valid`=1 loads `div` at that edge. A `cfg_div` of 0 is stored as 1.
  - In RUN, `cfg_ready`=0 and `cfg_valid` is ignored. The ratio never changes mid-run.
- **IDLE → RUN:**
  - Taken when `cmd_start`=1 and `cmd_stop`=0.
  - At that edge: count←0, remaining←`burst_len`, `clk_out`←0.
  - If `cfg_valid` arrives in the same edge, the new `div` governs this run.
- **RUN, each edge:**
  - If count==div−1: count←0, `tick`←1, `clk_out`←~`clk_out`.
  - Otherwise: count←count+1, `tick`←0.
  - All arithmetic is unsigned WIDTH-bit. The count never exceeds div−1.
- **Burst mode** (remaining≠0 at start):
  - Each tick decrements remaining.
  - The tick that takes remaining from 1 to 0 also sets `done`←1 and state←IDLE.
- **Continuous mode** (`burst_len`=0): ticks run until `cmd_stop`; `done` is never asserted.
- **RUN → IDLE on `cmd_stop`:**
  - Takes effect at the next edge and wins over a coincident terminal count.
  - Effects: no tick, no toggle, no `done`, count←0.
- `cmd_start` while in RUN is ignored; the run does not restart.
- In IDLE: `tick`=0 and `clk_out` holds its last value.
- `rst` asserted mid-run forces all reset values immediately (asynchronous), including `div`=DEFAULT_DIV.

## Timing
- **Start edge E0:** `busy` is high from E0.
- **First tick:** registered at edge E0+div and high for one cycle. Subsequent ticks follow every div cycles.
- **div=1:** `tick` is high on every cycle after E0 and `clk_out` toggles every cycle.
- **Burst of L ticks:** the last tick is at E0+L·div.
  - `done`=1 and `busy`=0 in the same cycle as the last tick.
  - `cfg_ready`=1 from that cycle on.
- **Back-to-back runs:** `cmd_start` is accepted at the edge after the final tick. The earliest next E0 is E0+L·div+1.
- **Stop:** `cmd_stop` sampled at edge S gives `busy`=0 and `tick`=0 from S.
- **Handshake:**
  - A transfer occurs at an edge where `cfg_valid`&`cfg_ready`.
  - `cfg_ready` is combinational from state (IDLE).
- `clk_out` and `tick` are registered; there is no combinational path from inputs to them.

## Test plan
- **Reset defaults:** assert `rst` -> all outputs at reset values, `cfg_ready`=1. Start with `burst_len`=0 and DEFAULT_DIV overridden to 4 -> first tick 4 cycles after start, then every 4.
- **Config then burst:** `cfg_div`=3, then start with `burst_len`=5 -> exactly 5 ticks spaced 3 cycles; `done` coincides with the 5th tick; `clk_out` ends at 1; `busy` falls with `done`.
- **Zero and one:**
  - `cfg_div`=0 -> behaves as div=1: tick every cycle, `clk_out` toggling every cycle.
  - `burst_len`=1 with div=1 -> single tick and `done` one cycle after start.
- **Stop collision:** div=4, continuous; assert `cmd_stop` on the cycle count==3 -> no tick, no `clk_out` toggle, `done`=0, `busy`=0.
- **Blocked config and ignored start:** `cfg_valid` with `cfg_div`=7 during RUN (div=2) -> no transfer, spacing stays 2. The same value after `done` is accepted. `cmd_start` during RUN causes no restart.
- **Async reset mid-run:** assert `rst` between edges during a div=5 burst -> outputs clear immediately. After release, `div`=DEFAULT_DIV and the block is idle until a new start.

Source files
------------

// File: rtl/clk_div_sched.sv
// Programmable tick scheduler: a divide-by-N counter with run/stop control,
// finite bursts or continuous ticking, and a ratio-reload handshake while idle.
module clk_div_sched #(
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 32'd50_000_000,
  parameter int          BURST_W     = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [WIDTH-1:0]   cfg_div,
  output logic               cfg_ready,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               clk_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]   DIV_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   DIV_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [BURST_W-1:0] REM_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] REM_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   div_r, div_s;
  logic [WIDTH-1:0]   count_r, count_s;
  logic [BURST_W-1:0] remaining_r, remaining_s;
  logic               tick_r, tick_s;
  logic               clk_out_r, clk_out_s;
  logic               done_r, done_s;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      div_r       <= DIV_RST;
      count_r     <= DIV_ZERO;
      remaining_r <= REM_ZERO;
      tick_r      <= 1'b0;
      clk_out_r   <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_r       <= div_s;
      count_r     <= count_s;
      remaining_r <= remaining_s;
      tick_r      <= tick_s;
      clk_out_r   <= clk_out_s;
      done_r      <= done_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    count_s     = count_r;
    remaining_s = remaining_r;
    tick_s      = 1'b0;
    clk_out_s   = clk_out_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A ratio accepted on the start edge already governs the new run.
        if (cfg_valid) begin
          div_s = (cfg_div == DIV_ZERO) ? DIV_ONE : cfg_div;
        end else begin
          div_s = div_r;
        end
        if (cmd_start && !cmd_stop) begin
          state_s     = ST_RUN;
          count_s     = DIV_ZERO;
          remaining_s = burst_len;
          clk_out_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_stop) begin
          state_s = ST_IDLE;
          count_s = DIV_ZERO;
        end else if (count_r == (div_r - DIV_ONE)) begin
          count_s   = DIV_ZERO;
          tick_s    = 1'b1;
          clk_out_s = ~clk_out_r;
          // remaining == 0 marks continuous mode and is never decremented.
          if (remaining_r != REM_ZERO) begin
            remaining_s = remaining_r - REM_ONE;
            if (remaining_r == REM_ONE) begin
              done_s  = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RUN;
            end
          end else begin
            remaining_s = remaining_r;
          end
        end else begin
          count_s = count_r + DIV_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign cfg_ready = (state_r == ST_IDLE);
  assign busy      = (state_r == ST_RUN);
  assign tick      = tick_r;
  assign clk_out   = clk_out_r;
  assign done      = done_r;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: stimulus queues expected tick events,
// a negedge monitor pops and compares whenever tick or done is presented.
module tb_clk_div_sched;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [31:0] cfg_div;
  logic        cfg_ready;
  logic        cmd_start;
  logic        cmd_stop;
  logic [15:0] burst_len;
  logic        tick;
  logic        clk_out;
  logic        busy;
  logic        done;

  typedef struct {
    int cyc;
    bit clk_out;
    bit done;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   e0;

  clk_div_sched #(
    .WIDTH(32),
    .DEFAULT_DIV(32'd4),
    .BURST_W(16)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .burst_len(burst_len),
    .tick(tick),
    .clk_out(clk_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every presented tick/done must match the head of the queue.
  always @(negedge clk_in) begin
    if (!rst && (tick || done)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: actual tick=%0b done=%0b expected none (cycle %0d)",
                 tick, done, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_level", int'(tick), 1);
        chk("tick_clk_out", int'(clk_out), int'(e.clk_out));
        chk("tick_done", int'(done), int'(e.done));
        chk("tick_busy", int'(busy), int'(e.busy));
      end
    end
  end

  task automatic push(input int c, input bit co, input bit dn, input bit bz);
    exp_t e;
    e.cyc = c; e.clk_out = co; e.done = dn; e.busy = bz;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: actual=%0d pending ticks expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_cfg(input int d);
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_div   = d;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  // Drive start at a negedge; e0 is the cycle index of the start edge.
  task automatic do_start(input int bl);
    @(negedge clk_in);
    cmd_start = 1'b1;
    burst_len = bl[15:0];
    @(negedge clk_in);
    e0        = cyc;
    cmd_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_div = 32'd0;
    cmd_start = 1'b0; cmd_stop = 1'b0; burst_len = 16'd0;
    #23;
    chk("rst_tick", int'(tick), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk_in);
    rst = 1'b0;

    // Continuous with default ratio 4, stopped mid-count.
    do_start(0);
    chk("t1_busy", int'(busy), 1);
    chk("t1_cfg_ready", int'(cfg_ready), 0);
    for (int k = 1; k <= 3; k++) push(e0 + 4 * k, k[0], 1'b0, 1'b1);
    wait_to(e0 + 13);
    cmd_stop = 1'b1;
    @(negedge clk_in);
    cmd_stop = 1'b0;
    chk("t1_stop_busy", int'(busy), 0);
    chk("t1_stop_tick", int'(tick), 0);
    chk("t1_stop_clk_out", int'(clk_out), 1);
    wait_to(e0 + 22);
    drained("t1_drained");

    // Config 3, burst of 5.
    do_cfg(3);
    do_start(5);
    for (int k = 1; k <= 5; k++) push(e0 + 3 * k, k[0], k == 5, k != 5);
    wait_to(e0 + 18);
    chk("t2_clk_out_end", int'(clk_out), 1);
    chk("t2_idle_busy", int'(busy), 0);
    chk("t2_cfg_ready", int'(cfg_ready), 1);
    drained("t2_drained");

    // cfg_div=0 loaded on the start edge acts as div=1.
    @(negedge clk_in);
    cfg_valid = 1'b1; cfg_div = 32'd0; cmd_start = 1'b1; burst_len = 16'd0;
    @(negedge clk_in);
    e0 = cyc; cfg_valid = 1'b0; cmd_start = 1'b0;
    for (int k = 1; k <= 4; k++) push(e0 + k, k[0], 1'b0, 1'b1);
    wait_to(e0 + 4);
    cmd_stop = 1'b1;
    @(negedge clk_in);
    cmd_stop = 1'b0;
    chk("t3_stop_busy", int'(busy), 0);
    wait_to(e0 + 8);
    drained("t3_drained");

    // Single-tick burst at div=1.
    do_start(1);
    push(e0 + 1, 1'b1, 1'b1, 1'b0);
    wait_to(e0 + 4);
    drained("t3b_drained");

    // Stop colliding with terminal count at div=4.
    do_cfg(4);
    do_start(0);
    push(e0 + 4, 1'b1, 1'b0, 1'b1);
    wait_to(e0 + 7);
    cmd_stop = 1'b1;
    @(negedge clk_in);
    cmd_stop = 1'b0;
    chk("t4_coll_tick", int'(tick), 0);
    chk("t4_coll_clk_out", int'(clk_out), 1);
    chk("t4_coll_done", int'(done), 0);
    chk("t4_coll_busy", int'(busy), 0);
    wait_to(e0 + 14);
    drained("t4_drained");

    // Config and start offered during a div=2 burst must be ignored.
    do_cfg(2);
    do_start(4);
    for (int k = 1; k <= 4; k++) push(e0 + 2 * k, k[0], k == 4, k != 4);
    wait_to(e0 + 1);
    cfg_valid = 1'b1; cfg_div = 32'd7; cmd_start = 1'b1; burst_len = 16'd9;
    @(negedge clk_in);
    chk("t5_cfg_ready_run", int'(cfg_ready), 0);
    @(negedge clk_in);
    cfg_valid = 1'b0; cmd_start = 1'b0;
    wait_to(e0 + 8);
    chk("t5_cfg_ready_done", int'(cfg_ready), 1);
    // Back-to-back: the same ratio is accepted on the edge after the last tick.
    cfg_valid = 1'b1; cfg_div = 32'd7; cmd_start = 1'b1; burst_len = 16'd1;
    @(negedge clk_in);
    e0 = cyc; cfg_valid = 1'b0; cmd_start = 1'b0;
    chk("t5_b2b_busy", int'(busy), 1);
    push(e0 + 7, 1'b1, 1'b1, 1'b0);
    wait_to(e0 + 10);
    drained("t5_drained");

    // Asynchronous reset between edges of a div=5 burst.
    do_cfg(5);
    do_start(3);
    push(e0 + 5, 1'b1, 1'b0, 1'b1);
    wait_to(e0 + 7);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_clk_out", int'(clk_out), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_tick", int'(tick), 0);
    chk("t6_rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk_in);
    rst = 1'b0;
    drained("t6_drained_rst");
    wait_to(cyc + 12);
    chk("t6_idle_busy", int'(busy), 0);
    do_start(0);
    push(e0 + 4, 1'b1, 1'b0, 1'b1);
    wait_to(e0 + 4);
    cmd_stop = 1'b1;
    @(negedge clk_in);
    cmd_stop = 1'b0;
    wait_to(e0 + 9);
    drained("t6_default_div");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
